// File: rtl/bck_pkg.sv
// ============================================================================
// Module   : bck_pkg
// Purpose  : Shared status encodings, context layout and slot-state encoding
//            for the SMEM backward-extension token path.
// Revision : 1.0
// ============================================================================
`default_nettype none

package bck_pkg;

    localparam int BCK_CTX_W = 138;

    // One-hot status shared with the stage-2 control register; all-zero is a bubble.
    localparam logic [5:0] F_init  = 6'b00_0001;
    localparam logic [5:0] F_run   = 6'b00_0010;
    localparam logic [5:0] F_break = 6'b00_0100;
    localparam logic [5:0] BCK_INI = 6'b00_1000;
    localparam logic [5:0] BCK_RUN = 6'b01_0000;
    localparam logic [5:0] BCK_END = 6'b10_0000;
    localparam logic [5:0] BUBBLE  = 6'b00_0000;

    localparam int PRIMARY_LSB   = 0;
    localparam int PRIMARY_MSB   = 63;
    localparam int READ_NUM_LSB  = 64;
    localparam int READ_NUM_MSB  = 73;
    localparam int FWD_SIZE_LSB  = 74;
    localparam int NEW_SIZE_LSB  = 81;
    localparam int NEW_LAST_LSB  = 88;
    localparam int CUR_WR_LSB    = 95;
    localparam int CUR_RD_LSB    = 102;
    localparam int MEM_WR_LSB    = 109;
    localparam int BCK_I_LSB     = 116;
    localparam int BCK_J_LSB     = 123;
    localparam int MIN_INTV_LSB  = 130;
    localparam int ITER_BND_BIT  = 137;

    typedef struct packed {
        logic        iteration_boundary;
        logic [6:0]  min_intv;
        logic [6:0]  backward_j;
        logic [6:0]  backward_i;
        logic [6:0]  mem_wr_addr;
        logic [6:0]  current_rd_addr;
        logic [6:0]  current_wr_addr;
        logic [6:0]  new_last_size;
        logic [6:0]  new_size;
        logic [6:0]  forward_size_n;
        logic [9:0]  read_num;
        logic [63:0] primary;
    } bck_ctx_t;

    typedef enum logic [1:0] {
        SLOT_FREE     = 2'd0,
        SLOT_INI_PEND = 2'd1,
        SLOT_WAIT     = 2'd2,
        SLOT_RUN_PEND = 2'd3
    } slot_state_e;

    function automatic logic [9:0] ctx_read_num(input logic [BCK_CTX_W-1:0] ctx);
        bck_ctx_t c;
        c = bck_ctx_t'(ctx);
        return c.read_num;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bck_rr_arbiter.sv
// ============================================================================
// Module   : bck_rr_arbiter
// Purpose  : Combinational round-robin pick of the first requesting slot at or
//            after the rr pointer, with wrap-around.
// Revision : 1.0
// ============================================================================
`default_nettype none

module bck_rr_arbiter #(
    parameter int NUM_SLOTS = 8,
    parameter int SLOT_W    = 3
) (
    input  logic [NUM_SLOTS-1:0] req,
    input  logic [SLOT_W-1:0]    rr,
    output logic [NUM_SLOTS-1:0] grant,
    output logic [SLOT_W-1:0]    grant_idx,
    output logic                 grant_valid
);

    logic [SLOT_W-1:0] w_idx;

    // NUM_SLOTS is a power of two, so SLOT_W-bit addition wraps for free.
    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        w_idx       = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            w_idx = rr + SLOT_W'(i);
            if (!grant_valid && req[w_idx]) begin
                grant_valid  = 1'b1;
                grant_idx    = w_idx;
                grant[w_idx] = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/bck_token_issuer.sv
// ============================================================================
// Module   : bck_token_issuer
// Purpose  : Holds NUM_SLOTS read contexts and injects BCK_INI/BCK_RUN tokens
//            into the backward pipeline ahead of stage 2.
//            Optional macro BCK_CHECK_EN adds err_sticky and a desc watchdog.
// Revision : 1.0
// ============================================================================
`default_nettype none

module bck_token_issuer
    import bck_pkg::*;
#(
    parameter int NUM_SLOTS = 8,
    parameter int SLOT_W    = 3,
    parameter int CTX_W     = BCK_CTX_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              desc_valid,
    output logic              desc_ready,
    input  logic [CTX_W-1:0]  desc_ctx,
    output logic [5:0]        tok_status,
    output logic [SLOT_W-1:0] tok_slot,
    output logic [CTX_W-1:0]  tok_ctx,
    input  logic              fb_valid,
    input  logic [SLOT_W-1:0] fb_slot,
    input  logic              fb_finish,
    input  logic [CTX_W-1:0]  fb_ctx,
    output logic              done_valid,
    output logic [9:0]        done_read_num,
`ifdef BCK_CHECK_EN
    output logic              err_sticky,
`endif
    output logic              busy
);

    slot_state_e          r_state     [NUM_SLOTS];
    slot_state_e          w_state_nxt [NUM_SLOTS];
    logic [CTX_W-1:0]     r_ctx       [NUM_SLOTS];
    logic [SLOT_W-1:0]    r_rr;

    logic [NUM_SLOTS-1:0] w_free;
    logic [NUM_SLOTS-1:0] w_pend;
    logic [NUM_SLOTS-1:0] w_grant;
    logic [SLOT_W-1:0]    w_grant_idx;
    logic                 w_grant_valid;
    logic [SLOT_W-1:0]    w_alloc_idx;
    logic                 w_alloc;
    logic                 w_issue;
    logic                 w_fb_hit;

    bck_rr_arbiter #(
        .NUM_SLOTS (NUM_SLOTS),
        .SLOT_W    (SLOT_W)
    ) u_arb (
        .req         (w_pend),
        .rr          (r_rr),
        .grant       (w_grant),
        .grant_idx   (w_grant_idx),
        .grant_valid (w_grant_valid)
    );

    // Status decode of the registered slot states; nothing here sees this cycle's updates.
    always_comb begin
        w_free = '0;
        w_pend = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            w_free[i] = (r_state[i] == SLOT_FREE);
            w_pend[i] = (r_state[i] == SLOT_INI_PEND) || (r_state[i] == SLOT_RUN_PEND);
        end
    end

    always_comb begin
        w_alloc_idx = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (w_free[i]) begin
                w_alloc_idx = SLOT_W'(i);
            end
        end
    end

    assign desc_ready = |w_free;
    assign busy       = ~&w_free;
    assign w_alloc    = desc_valid && desc_ready;
    assign w_issue    = !stall && w_grant_valid;
    assign w_fb_hit   = fb_valid && (r_state[fb_slot] == SLOT_WAIT);

    // Allocation, issue and feedback only ever target FREE, PEND and WAIT slots respectively.
    always_comb begin
        for (int i = 0; i < NUM_SLOTS; i++) begin
            w_state_nxt[i] = r_state[i];
            if (w_alloc && (w_alloc_idx == SLOT_W'(i))) begin
                w_state_nxt[i] = SLOT_INI_PEND;
            end
            if (w_issue && w_grant[i]) begin
                w_state_nxt[i] = SLOT_WAIT;
            end
            if (w_fb_hit && (fb_slot == SLOT_W'(i))) begin
                w_state_nxt[i] = fb_finish ? SLOT_FREE : SLOT_RUN_PEND;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                r_state[i] <= SLOT_FREE;
                r_ctx[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                r_state[i] <= w_state_nxt[i];
            end
            if (w_alloc) begin
                r_ctx[w_alloc_idx] <= desc_ctx;
            end
            if (w_fb_hit && !fb_finish) begin
                r_ctx[fb_slot] <= fb_ctx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tok_status <= BUBBLE;
            tok_slot   <= '0;
            tok_ctx    <= '0;
            r_rr       <= '0;
        end else if (!stall) begin
            if (w_grant_valid) begin
                tok_status <= (r_state[w_grant_idx] == SLOT_INI_PEND) ? BCK_INI : BCK_RUN;
                tok_slot   <= w_grant_idx;
                tok_ctx    <= r_ctx[w_grant_idx];
                r_rr       <= w_grant_idx + SLOT_W'(1);
            end else begin
                tok_status <= BUBBLE;
                tok_slot   <= '0;
                tok_ctx    <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            done_valid    <= 1'b0;
            done_read_num <= '0;
        end else begin
            done_valid <= w_fb_hit && fb_finish;
            if (w_fb_hit && fb_finish) begin
                done_read_num <= ctx_read_num(r_ctx[fb_slot]);
            end
        end
    end

`ifdef BCK_CHECK_EN
    logic [9:0] r_wdog;
    logic       w_wdog_exp;

    // Saturating count of consecutive refused offers; an offer refused while saturated trips the error.
    assign w_wdog_exp = desc_valid && !desc_ready && (r_wdog == 10'h3FF);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wdog     <= '0;
            err_sticky <= 1'b0;
        end else begin
            if (!desc_valid || desc_ready) begin
                r_wdog <= '0;
            end else if (r_wdog != 10'h3FF) begin
                r_wdog <= r_wdog + 10'd1;
            end
            if ((fb_valid && !w_fb_hit) || w_wdog_exp) begin
                err_sticky <= 1'b1;
            end
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_bck_token_issuer.sv
// ============================================================================
// Module   : tb_bck_token_issuer
// Purpose  : Scoreboard bench for bck_token_issuer: directed stimulus pushes
//            expected tokens/retirements, a negedge monitor pops and compares.
// Revision : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_bck_token_issuer;
    import bck_pkg::*;

    localparam int SW = 3;
    localparam int CW = 138;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          stall = 1'b0;
    logic          desc_valid = 1'b0;
    logic [CW-1:0] desc_ctx = '0;
    logic          fb_valid = 1'b0;
    logic [SW-1:0] fb_slot = '0;
    logic          fb_finish = 1'b0;
    logic [CW-1:0] fb_ctx = '0;
    logic          desc_ready;
    logic [5:0]    tok_status;
    logic [SW-1:0] tok_slot;
    logic [CW-1:0] tok_ctx;
    logic          done_valid;
    logic [9:0]    done_read_num;
    logic          busy;
`ifdef BCK_CHECK_EN
    logic          err_sticky;
`endif

    typedef struct packed {
        logic [5:0]    st;
        logic [SW-1:0] slot;
        logic [CW-1:0] ctx;
    } tok_t;

    tok_t       exp_tok  [$];
    logic [9:0] exp_done [$];
    tok_t       m_tok;
    logic [9:0] m_rn;
    logic       last_stall = 1'b1;
    int         n_vec = 0;
    int         n_err = 0;

    bck_token_issuer u_dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .desc_valid    (desc_valid),
        .desc_ready    (desc_ready),
        .desc_ctx      (desc_ctx),
        .tok_status    (tok_status),
        .tok_slot      (tok_slot),
        .tok_ctx       (tok_ctx),
        .fb_valid      (fb_valid),
        .fb_slot       (fb_slot),
        .fb_finish     (fb_finish),
        .fb_ctx        (fb_ctx),
        .done_valid    (done_valid),
        .done_read_num (done_read_num),
`ifdef BCK_CHECK_EN
        .err_sticky    (err_sticky),
`endif
        .busy          (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [CW-1:0] mk(input int rn, input int salt);
        logic [CW-1:0] c;
        c          = '0;
        c[63:0]    = {32'(salt) ^ 32'hA5A5_0000, 32'h1357_0000 + 32'(salt)};
        c[73:64]   = 10'(rn);
        c[137:74]  = {32'(salt * 7 + 1), 32'hC0DE_0000 | 32'(salt)};
        return c;
    endfunction

    task automatic push_tok(input logic [5:0] st, input int slot, input logic [CW-1:0] c);
        tok_t t;
        t.st   = st;
        t.slot = SW'(slot);
        t.ctx  = c;
        exp_tok.push_back(t);
    endtask

    task automatic fb(input int slot, input logic fin, input logic [CW-1:0] c);
        fb_valid  = 1'b1;
        fb_slot   = SW'(slot);
        fb_finish = fin;
        fb_ctx    = c;
        step(1);
        fb_valid  = 1'b0;
        fb_finish = 1'b0;
    endtask

    task automatic alloc(input logic [CW-1:0] c);
        desc_valid = 1'b1;
        desc_ctx   = c;
        step(1);
        desc_valid = 1'b0;
    endtask

    // A token is new only if the output register was allowed to load at the last edge.
    always @(posedge clk) last_stall = stall;

    always @(negedge clk) begin
        if (rst === 1'b1 && !last_stall && tok_status !== BUBBLE) begin
            if (exp_tok.size() == 0) begin
                chk("tok_unexpected", CW'(tok_status), CW'(BUBBLE));
            end else begin
                m_tok = exp_tok.pop_front();
                chk("tok_status", CW'(tok_status), CW'(m_tok.st));
                chk("tok_slot", CW'(tok_slot), CW'(m_tok.slot));
                chk("tok_ctx", tok_ctx, m_tok.ctx);
            end
        end
        if (rst === 1'b1 && done_valid === 1'b1) begin
            if (exp_done.size() == 0) begin
                chk("done_unexpected", CW'(done_valid), CW'(0));
            end else begin
                m_rn = exp_done.pop_front();
                chk("done_read_num", CW'(done_read_num), CW'(m_rn));
            end
        end
    end

    initial begin
        logic [CW-1:0] c1, c2, s2, t0, t2, t5;
        logic          acc;
        int            k;

        // Reset values while rst is held low
        step(2);
        chk("rst_tok_status", CW'(tok_status), CW'(BUBBLE));
        chk("rst_tok_slot", CW'(tok_slot), '0);
        chk("rst_tok_ctx", tok_ctx, '0);
        chk("rst_done_valid", CW'(done_valid), '0);
        chk("rst_done_rn", CW'(done_read_num), '0);
        chk("rst_busy", CW'(busy), '0);
        chk("rst_desc_ready", CW'(desc_ready), CW'(1));
`ifdef BCK_CHECK_EN
        chk("rst_err_sticky", CW'(err_sticky), '0);
`endif
        @(negedge clk) rst = 1'b1;
        step(1);

        // Single read: INI, RUN, RUN, then retire read_num 5
        c1 = mk(5, 2);
        c2 = mk(5, 3);
        push_tok(BCK_INI, 0, mk(5, 1));
        push_tok(BCK_RUN, 0, c1);
        push_tok(BCK_RUN, 0, c2);
        exp_done.push_back(10'd5);
        alloc(mk(5, 1));
        chk("single_busy", CW'(busy), CW'(1));
        step(4);
        fb(0, 1'b0, c1);
        step(4);
        fb(0, 1'b0, c2);
        step(4);
        fb(0, 1'b1, mk(5, 99));
        chk("single_done_valid", CW'(done_valid), CW'(1));
        chk("single_busy_drop", CW'(busy), '0);
        chk("single_desc_ready", CW'(desc_ready), CW'(1));
        step(2);

        // Fill: eight accepts back-to-back, ninth waits for a retirement
        for (int i = 0; i < 8; i++) push_tok(BCK_INI, i, mk(10 + i, 10 + i));
        push_tok(BCK_INI, 3, mk(18, 18));
        k          = 0;
        desc_valid = 1'b1;
        desc_ctx   = mk(10, 10);
        for (int cyc = 0; cyc < 20 && k < 8; cyc++) begin
            acc = desc_ready;
            step(1);
            if (acc) begin
                k++;
                desc_ctx = mk(10 + k, 10 + k);
            end
        end
        chk("fill_accepts", CW'(k), CW'(8));
        chk("fill_ready_low", CW'(desc_ready), '0);
        step(2);
        chk("fill_ready_held_low", CW'(desc_ready), '0);
        exp_done.push_back(10'd13);
        fb(3, 1'b1, mk(13, 0));
        chk("fill_done_valid", CW'(done_valid), CW'(1));
        chk("fill_ready_after_free", CW'(desc_ready), CW'(1));
        step(1);
        desc_valid = 1'b0;
        chk("fill_ninth_taken", CW'(desc_ready), '0);
        step(2);
        for (int i = 0; i < 8; i++) begin
            exp_done.push_back((i == 3) ? 10'd18 : 10'(10 + i));
            fb(i, 1'b1, mk(0, 0));
        end
        step(1);
        chk("fill_drained_busy", CW'(busy), '0);

        // Round-robin: slots 0,2,5 pending with rr past 5 -> 0,2,5
        for (int i = 0; i < 6; i++) push_tok(BCK_INI, i, mk(20 + i, 20 + i));
        for (int i = 0; i < 6; i++) alloc(mk(20 + i, 20 + i));
        step(2);
        push_tok(BCK_RUN, 0, mk(20, 40));
        push_tok(BCK_RUN, 2, mk(22, 42));
        push_tok(BCK_RUN, 5, mk(25, 45));
        stall = 1'b1;
        fb(0, 1'b0, mk(20, 40));
        fb(2, 1'b0, mk(22, 42));
        fb(5, 1'b0, mk(25, 45));
        stall = 1'b0;
        step(4);

        // Issue slot 2 alone so rr = 3, then stall 3 cycles while 5,0,2 return
        s2 = mk(22, 50);
        push_tok(BCK_RUN, 2, s2);
        fb(2, 1'b0, s2);
        step(1);
        t5 = mk(25, 55);
        t0 = mk(20, 60);
        t2 = mk(22, 62);
        push_tok(BCK_RUN, 5, t5);
        push_tok(BCK_RUN, 0, t0);
        push_tok(BCK_RUN, 2, t2);
        stall = 1'b1;
        fb(5, 1'b0, t5);
        chk("stall_hold_status_1", CW'(tok_status), CW'(BCK_RUN));
        chk("stall_hold_ctx_1", tok_ctx, s2);
        fb(0, 1'b0, t0);
        chk("stall_hold_slot_2", CW'(tok_slot), CW'(2));
        chk("stall_hold_ctx_2", tok_ctx, s2);
        fb(2, 1'b0, t2);
        chk("stall_hold_slot_3", CW'(tok_slot), CW'(2));
        chk("stall_hold_ctx_3", tok_ctx, s2);
        stall = 1'b0;
        step(1);
        chk("stall_release_slot", CW'(tok_slot), CW'(5));
        step(3);
        for (int i = 0; i < 6; i++) begin
            exp_done.push_back(10'(20 + i));
            fb(i, 1'b1, mk(0, 0));
        end
        step(1);
        chk("rr_drained_busy", CW'(busy), '0);

        // Asynchronous reset mid-cycle with four live slots
        for (int i = 0; i < 4; i++) push_tok(BCK_INI, i, mk(30 + i, 30 + i));
        for (int i = 0; i < 4; i++) alloc(mk(30 + i, 30 + i));
        step(1);
        chk("prereset_status", CW'(tok_status), CW'(BCK_INI));
        chk("prereset_busy", CW'(busy), CW'(1));
        #6;
        rst = 1'b0;
        #1;
        chk("arst_tok_status", CW'(tok_status), CW'(BUBBLE));
        chk("arst_tok_ctx", tok_ctx, '0);
        chk("arst_busy", CW'(busy), '0);
        @(negedge clk) rst = 1'b1;
        step(1);
        chk("arst_desc_ready", CW'(desc_ready), CW'(1));
        chk("arst_status_after", CW'(tok_status), CW'(BUBBLE));

        // Feedback to a FREE slot is not a retirement
        fb(6, 1'b1, mk(77, 77));
        chk("stray_no_done", CW'(done_valid), '0);
        chk("stray_busy", CW'(busy), '0);
`ifdef BCK_CHECK_EN
        chk("err_set", CW'(err_sticky), CW'(1));
        step(3);
        chk("err_stays", CW'(err_sticky), CW'(1));
        #3;
        rst = 1'b0;
        #1;
        chk("err_cleared", CW'(err_sticky), '0);
        @(negedge clk) rst = 1'b1;
`endif

        for (int cyc = 0; cyc < 50 && (exp_tok.size() != 0 || exp_done.size() != 0); cyc++) step(1);
        chk("tok_queue_empty", CW'(exp_tok.size()), '0);
        chk("done_queue_empty", CW'(exp_done.size()), '0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
